mm_acc: RTL and testbench

Output-side companion to the sign-magnitude multiplier wrapper. It accepts a stream of sign-magnitude products (sign in MSB, 2*DW-bit magnitude) over a valid/ready handshake and converts each product back to two's complement. It accumulates the products of one packet, delimited by a last flag, and presents the two's-complement sum, beat count and overflow flag on a valid/ready output port. It sits between the multiplier array and the result writeback.

---
 rtl/mm_acc_if.sv | 34 +++
 rtl/mm_acc.sv | 160 ++++++++++++++++
 tb/tb_mm_acc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mm_acc_if.sv
// Purpose : stream bundle between the product source, mm_acc and result writeback.
// Latency : none, wires only.
// Backpr. : in_* is valid/ready from the source; out_* is valid/ready to the writeback.
//
// Signals (named from the accumulator's point of view):
//   in_valid_i/in_ready_o/in_q_i/in_last_i : sign-magnitude product beats, last closes a packet
//   out_valid_o/out_ready_i                : packet result handshake
//   out_acc_o/out_cnt_o/out_ovf_o          : packet sum, beat count, sticky overflow
// Modports: master = stream producer/consumer side, slave = the accumulator.
interface mm_acc_if #(
    parameter int DW = 8,
    parameter int AW = 32,
    parameter int CW = 8
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2*DW:0]   in_q_i;
    logic            in_last_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [AW-1:0]   out_acc_o;
    logic [CW-1:0]   out_cnt_o;
    logic            out_ovf_o;

    modport master (
        output in_valid_i, in_q_i, in_last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_acc_o, out_cnt_o, out_ovf_o
    );

    modport slave (
        input  in_valid_i, in_q_i, in_last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_acc_o, out_cnt_o, out_ovf_o
    );
endinterface

// File: rtl/mm_acc.sv
// Purpose : converts sign-magnitude products to two's complement and sums each packet.
// Latency : result valid the cycle after the last beat is accepted.
// Backpr. : no beats taken while a result is held; 1-cycle bubble per packet.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous clear, drops partial sum and any pending result
//   bus    : mm_acc_if.slave, input product stream and output result stream
// Build option: define MM_ACC_SAT_EN to clamp each add to the signed AW range
// instead of wrapping modulo 2^AW.
module mm_acc #(
    parameter int DW = 8,
    parameter int AW = 32,
    parameter int CW = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    mm_acc_if.slave    bus
);

    // The accumulator must hold a full-magnitude product plus its sign.
    if (AW < 2*DW+1) begin : g_bad_aw
        $error("mm_acc: AW must be >= 2*DW+1");
    end

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_in_rdy;
    logic            w_out_vld;
    logic            w_beat;
    logic            w_close;

    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic [AW-1:0]   r_out_acc;
    logic [CW-1:0]   r_out_cnt;
    logic            r_out_ovf;

    logic [AW-1:0]   w_mag_ext;
    logic [AW-1:0]   w_value;
    logic [AW-1:0]   w_sum_raw;
    logic [AW-1:0]   w_sum;
    logic            w_add_ovf;
    logic [CW-1:0]   w_cnt_inc;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_out_vld   = 1'b0;
        w_beat      = 1'b0;
        w_close     = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_rdy = 1'b1;
                // A beat coinciding with clr is thrown away.
                if (bus.in_valid_i && !clr_i) begin
                    w_beat = 1'b1;
                    if (bus.in_last_i) begin
                        w_close     = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                w_out_vld = 1'b1;
                if (bus.out_ready_i) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
        // Clear beats both the last flag and the output handshake.
        if (clr_i) begin
            w_state_nxt = ST_ACC;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_mag_ext = {{(AW-2*DW){1'b0}}, bus.in_q_i[2*DW-1:0]};
        // Negative zero negates to zero, so no special case is needed.
        w_value   = bus.in_q_i[2*DW] ? (ACC_MIN ^ ACC_MIN) - w_mag_ext : w_mag_ext;
        w_sum_raw = r_acc + w_value;
        // Signed overflow: operands agree in sign, result disagrees.
        w_add_ovf = (r_acc[AW-1] == w_value[AW-1]) && (w_sum_raw[AW-1] != r_acc[AW-1]);
`ifdef MM_ACC_SAT_EN
        // Clamp toward the side the operands were on; later adds start from the clamp.
        if (w_add_ovf) begin
            w_sum = r_acc[AW-1] ? ACC_MIN : ACC_MAX;
        end else begin
            w_sum = w_sum_raw;
        end
`else
        w_sum = w_sum_raw;
`endif
        w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_acc <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
        end else if (clr_i) begin
            // Result registers keep their value; they are don't-care once
            // out_valid drops.
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_close) begin
            r_out_acc <= w_sum;
            r_out_cnt <= w_cnt_inc;
            r_out_ovf <= r_ovf | w_add_ovf;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_add_ovf;
        end
    end

    // All outputs come straight from state or registers.
    assign bus.in_ready_o  = w_in_rdy;
    assign bus.out_valid_o = w_out_vld;
    assign bus.out_acc_o   = r_out_acc;
    assign bus.out_cnt_o   = r_out_cnt;
    assign bus.out_ovf_o   = r_out_ovf;

endmodule

// File: tb/tb_mm_acc.sv
// Purpose : directed self-checking bench for mm_acc (AW=32 and AW=17 instances).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpr. : out_ready held low for several cycles to exercise the hold state.
module tb_mm_acc;

    logic clk_i;
    logic rst_ni;
    logic clr_i;
    logic clr17;

    int n_cmp;
    int n_fail;

    mm_acc_if #(.DW(8), .AW(32), .CW(8)) bus ();
    mm_acc_if #(.DW(8), .AW(17), .CW(8)) bus17 ();

    mm_acc #(.DW(8), .AW(32), .CW(8)) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .bus    (bus)
    );

    mm_acc #(.DW(8), .AW(17), .CW(8)) u_dut17 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr17),
        .bus    (bus17)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat for one clock; the block must be ready when offered.
    task automatic beat(input logic [16:0] q, input logic last);
        chk("in_ready_before_beat", 64'(bus.in_ready_o), 64'd1);
        bus.in_valid_i = 1'b1;
        bus.in_q_i     = q;
        bus.in_last_i  = last;
        @(negedge clk_i);
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        bus.in_q_i     = '0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] acc,
                           input logic [7:0] cnt, input logic ovf);
        chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
        chk({tag, "_ready"}, 64'(bus.in_ready_o), 64'd0);
        chk({tag, "_acc"},   64'(bus.out_acc_o),  64'(acc));
        chk({tag, "_cnt"},   64'(bus.out_cnt_o),  64'(cnt));
        chk({tag, "_ovf"},   64'(bus.out_ovf_o),  64'(ovf));
    endtask

    task automatic pop(input string tag);
        bus.out_ready_i = 1'b1;
        @(negedge clk_i);
        bus.out_ready_i = 1'b0;
        chk({tag, "_pop_valid"}, 64'(bus.out_valid_o), 64'd0);
        chk({tag, "_pop_ready"}, 64'(bus.in_ready_o), 64'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_ni = 1'b0;
        clr_i  = 1'b0;
        clr17  = 1'b0;
        bus.in_valid_i    = 1'b0;
        bus.in_q_i        = '0;
        bus.in_last_i     = 1'b0;
        bus.out_ready_i   = 1'b0;
        bus17.in_valid_i  = 1'b0;
        bus17.in_q_i      = '0;
        bus17.in_last_i   = 1'b0;
        bus17.out_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 64'(bus.in_ready_o),  64'd1);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_acc",   64'(bus.out_acc_o),   64'd0);
        chk("rst_cnt",   64'(bus.out_cnt_o),   64'd0);
        chk("rst_ovf",   64'(bus.out_ovf_o),   64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single negative beat: -6, valid the cycle after acceptance
        beat(17'h1_0006, 1'b1);
        chk_res("neg6", 32'hFFFF_FFFA, 8'd1, 1'b0);
        pop("neg6");

        // +100, -30, +5 = 75
        beat(17'h0_0064, 1'b0);
        chk("mid_pkt_valid", 64'(bus.out_valid_o), 64'd0);
        beat(17'h1_001E, 1'b0);
        beat(17'h0_0005, 1'b1);
        chk_res("sum75", 32'd75, 8'd3, 1'b0);
        pop("sum75");
        beat(17'h0_0007, 1'b1);
        chk_res("sum7", 32'd7, 8'd1, 1'b0);
        pop("sum7");

        // Negative zero contributes nothing
        beat(17'h1_0000, 1'b0);
        beat(17'h0_0003, 1'b1);
        chk_res("negzero", 32'd3, 8'd2, 1'b0);
        pop("negzero");

        // Backpressure: result held, offered beats refused
        beat(17'h0_0001, 1'b1);
        bus.in_valid_i = 1'b1;
        bus.in_q_i     = 17'h0_0032;
        bus.in_last_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk_res("hold", 32'd1, 8'd1, 1'b0);
        end
        bus.in_valid_i  = 1'b0;
        bus.in_last_i   = 1'b0;
        pop("hold");
        beat(17'h0_0002, 1'b1);
        chk_res("after_hold", 32'd2, 8'd1, 1'b0);
        pop("after_hold");

        // AW=17 overflow: 0x8000 + 0x8000
        bus17.in_valid_i = 1'b1;
        bus17.in_q_i     = 17'h0_8000;
        bus17.in_last_i  = 1'b0;
        @(negedge clk_i);
        bus17.in_last_i  = 1'b1;
        @(negedge clk_i);
        bus17.in_valid_i = 1'b0;
        bus17.in_last_i  = 1'b0;
        chk("aw17_valid", 64'(bus17.out_valid_o), 64'd1);
`ifdef MM_ACC_SAT_EN
        chk("aw17_acc", 64'(bus17.out_acc_o), 64'h0FFFF);
`else
        chk("aw17_acc", 64'(bus17.out_acc_o), 64'h10000);
`endif
        chk("aw17_cnt", 64'(bus17.out_cnt_o), 64'd2);
        chk("aw17_ovf", 64'(bus17.out_ovf_o), 64'd1);
        bus17.out_ready_i = 1'b1;
        @(negedge clk_i);
        bus17.out_ready_i = 1'b0;
        chk("aw17_pop_valid", 64'(bus17.out_valid_o), 64'd0);

        // clr coincident with the last beat: packet discarded
        beat(17'h0_0004, 1'b0);
        clr_i          = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_q_i     = 17'h0_0008;
        bus.in_last_i  = 1'b1;
        @(negedge clk_i);
        clr_i          = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        chk("clr_valid", 64'(bus.out_valid_o), 64'd0);
        chk("clr_ready", 64'(bus.in_ready_o),  64'd1);
        beat(17'h0_0009, 1'b1);
        chk_res("after_clr", 32'd9, 8'd1, 1'b0);

        // clr wins over a held result even without out_ready
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("clr_hold_valid", 64'(bus.out_valid_o), 64'd0);
        chk("clr_hold_ready", 64'(bus.in_ready_o),  64'd1);

        // Reset mid-packet: everything back to reset values
        beat(17'h0_0004, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("midrst_acc",   64'(bus.out_acc_o),   64'd0);
        chk("midrst_cnt",   64'(bus.out_cnt_o),   64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_idle_valid", 64'(bus.out_valid_o), 64'd0);
        beat(17'h0_0009, 1'b1);
        chk_res("after_rst", 32'd9, 8'd1, 1'b0);
        pop("after_rst");

        // Beat count saturates at 255 while the sum keeps going
        for (int i = 0; i < 299; i++) begin
            beat(17'h0_0001, 1'b0);
        end
        chk("sat_mid_valid", 64'(bus.out_valid_o), 64'd0);
        beat(17'h0_0001, 1'b1);
        chk_res("cnt_sat", 32'd300, 8'd255, 1'b0);
        pop("cnt_sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
